// File: rtl/aes_byte_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_byte_if_if
//  Description : Byte-stream handshake bundle for the AES byte front end.
//                Carries the 8-bit input stream (toward the block) and the
//                8-bit ciphertext stream (away from the block).
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_byte_if_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Producer/consumer side of the byte bus
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Front-end block side of the byte bus
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/aes_byte_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_byte_if
//  Description : Byte-serial front end for an iterative AES-128 core.
//                Assembles 16 key bytes then 16 plaintext bytes, releases the
//                core from reset, waits for done (with timeout) and streams
//                the 16 ciphertext bytes out, MSB byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_byte_if #(
    parameter int TIMEOUT = 1023
) (
    input  wire logic         clk,
    input  wire logic         rst,
    aes_byte_if_if.slave      bus,
    output logic [127:0]      core_din,
    output logic [127:0]      core_keyin,
    output logic              core_rst,
    input  wire logic [127:0] core_dout,
    input  wire logic         core_done,
    output logic              busy,
    output logic              err
);

    // Timeout counter is wide enough to hold TIMEOUT itself, so it never wraps
    localparam int                c_to_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD_KEY = 2'd0,
        S_LOAD_PT  = 2'd1,
        S_WAIT     = 2'd2,
        S_UNLOAD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [c_to_w-1:0]   to_q, to_d;
    logic [127:0]        key_q, key_d;
    logic [127:0]        pt_q, pt_d;
    logic [127:0]        sh_q, sh_d;
    logic                core_rst_q, core_rst_d;
    logic                err_q, err_d;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_last_byte;

    // Handshake-side outputs are pure state decodes
    assign bus.in_ready  = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_PT);
    assign bus.out_valid = (state_q == S_UNLOAD);
    assign busy          = (state_q == S_WAIT) || (state_q == S_UNLOAD);

    assign bus.out_data  = sh_q[127:120];
    assign core_din      = pt_q;
    assign core_keyin    = key_q;
    assign core_rst      = core_rst_q;
    assign err           = err_q;

    assign w_in_fire     = bus.in_valid && bus.in_ready;
    assign w_out_fire    = bus.out_valid && bus.out_ready;
    assign w_last_byte   = (cnt_q == 4'd15);

    // Next-state and datapath updates for the load / wait / unload sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        key_d      = key_q;
        pt_d       = pt_q;
        sh_d       = sh_q;
        core_rst_d = core_rst_q;
        err_d      = err_q;

        case (state_q)
            S_LOAD_KEY: begin
                if (w_in_fire) begin
                    key_d = {key_q[119:0], bus.in_data};
                    // 4-bit counter wraps to 0 naturally after the 16th byte
                    cnt_d = cnt_q + 4'd1;
                    if (w_last_byte) begin
                        state_d = S_LOAD_PT;
                    end
                end
            end

            S_LOAD_PT: begin
                if (w_in_fire) begin
                    pt_d  = {pt_q[119:0], bus.in_data};
                    cnt_d = cnt_q + 4'd1;
                    if (w_last_byte) begin
                        // Release the core on the same edge that takes the last byte
                        state_d    = S_WAIT;
                        core_rst_d = 1'b0;
                        to_d       = '0;
                    end
                end
            end

            S_WAIT: begin
                to_d = to_q + {{(c_to_w-1){1'b0}}, 1'b1};
                // Done has priority over a coincident timeout
                if (core_done) begin
                    sh_d       = core_dout;
                    core_rst_d = 1'b1;
                    state_d    = S_UNLOAD;
                end else if (to_q == c_to_last) begin
                    err_d      = 1'b1;
                    core_rst_d = 1'b1;
                    state_d    = S_LOAD_KEY;
                end
            end

            S_UNLOAD: begin
                if (w_out_fire) begin
                    sh_d  = {sh_q[119:0], 8'h00};
                    cnt_d = cnt_q + 4'd1;
                    if (w_last_byte) begin
                        state_d = S_LOAD_KEY;
                    end
                end
            end

            default: begin
                state_d = S_LOAD_KEY;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD_KEY;
            cnt_q      <= 4'd0;
            to_q       <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            sh_q       <= '0;
            core_rst_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            sh_q       <= sh_d;
            core_rst_q <= core_rst_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/aes_byte_if.md
# aes_byte_if

Byte-serial front end for the iterative AES-128 encryption core. It assembles a 16-byte key and a 16-byte plaintext from an 8-bit valid/ready input stream, then holds the core in reset until both are loaded. After releasing the core it waits for `core_done` and streams the 16 ciphertext bytes out on an 8-bit valid/ready port. It sits directly between the system byte bus and the core's `din`/`keyin`/`dout`/`done` pins.

## Interface
- `TIMEOUT`, default 1023: maximum cycles spent in WAIT before the run is aborted.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_data`  in  8  input byte
- `in_valid`  in  1  input byte valid
- `in_ready`  out  1  block accepts a byte this cycle
- `out_data`  out  8  ciphertext byte
- `out_valid`  out  1  ciphertext byte valid
- `out_ready`  in  1  sink accepts a byte this cycle
- `core_din`  out  128  plaintext to the core
- `core_keyin`  out  128  key to the core
- `core_rst`  out  1  registered reset to the core; 1 = core held in reset
- `core_dout`  in  128  ciphertext from the core
- `core_done`  in  1  core completion flag
- `busy`  out  1  high in WAIT and UNLOAD
- `err`  out  1  sticky timeout flag; cleared only by `rst`

## Operation
- **Byte order.** The first byte of each 16-byte group maps to bits [127:120]; the last maps to [7:0].
- **Frame.** A frame is 16 key bytes followed by 16 plaintext bytes. There is no framing signal; the byte counter alone defines position.
- **States.** LOAD_KEY, LOAD_PT, WAIT, UNLOAD.
- **LOAD_KEY**
  - `in_ready`=1.
  - On each accepted byte (`in_valid`&&`in_ready`), shift it into `core_keyin` and increment the 4-bit byte counter.
  - After the 16th byte, clear the counter and go to LOAD_PT.
- **LOAD_PT**
  - Same as LOAD_KEY, but bytes go into `core_din`.
  - On the 16th byte, go to WAIT, set `core_rst`<=0 and clear the timeout counter.
- **WAIT**
  - `in_ready`=0.
  - `core_din` and `core_keyin` are frozen.
  - The timeout counter increments every cycle.
  - If `core_done`=1: load `core_dout` into the output shift register, set `core_rst`<=1 and go to UNLOAD.
  - Else if the counter equals TIMEOUT-1: set `err`<=1, set `core_rst`<=1 and go to LOAD_KEY. No output is produced.
  - If `core_done` and the timeout coincide, `core_done` wins and `err` is not set.
- **UNLOAD**
  - `out_valid`=1 and `out_data` = shift register [127:120].
  - On `out_valid`&&`out_ready`, shift left by 8 and increment the counter.
  - After the 16th transfer, go to LOAD_KEY with the counter at 0.
  - While `out_ready`=0, `out_data` is held stable.
- **Key storage.** `core_keyin` is reloaded on every frame; there is no key retention mode.
- **Counter widths.**
  - The byte counter is 4 bits and wraps 15→0 exactly at each group boundary.
  - The timeout counter is $clog2(TIMEOUT+1) bits and never wraps.
- **Reset.** `rst` may be asserted at any time. The block aborts immediately, discards partial frames and ciphertext, and does not resume.

## Timing
- **Reset values.**
  - state=LOAD_KEY, `in_ready`=1, `out_valid`=0, `out_data`=0.
  - `core_din`=0, `core_keyin`=0, `core_rst`=1.
  - `busy`=0, `err`=0, all counters 0.
- **Input throughput.** One byte per cycle with `in_valid` held high.
- **Load latency.** 32 cycles minimum from the first key byte to `core_rst` falling. `core_rst` falls on the edge that accepts the 32nd byte.
- **Core start.** The core runs from the first edge after `core_rst` falls. Its IDLE state samples `core_din`/`core_keyin` on that edge.
- **Done sampling.** `core_done` is sampled in WAIT only; in all other states it is ignored.
- **Capture to output.** `out_valid` rises on the edge after `core_done` is seen. `core_rst` rises on that same edge, clearing the core's `done`.
- **Output throughput.** One byte per cycle with `out_ready` held high. 16 cycles minimum in UNLOAD.
- **Next frame.** `in_ready` returns to 1 on the edge that completes the 16th output transfer.
- **Outputs.** `in_ready`, `out_valid` and `busy` are decoded from state; all other outputs are registered.

## Test plan
- **FIPS-197 vector.**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, core model returning 69c4e0d86a7b0430d8cdb78070b4c55a after 50 cycles.
  - Required response: `core_keyin`/`core_din` match the inputs exactly when `core_rst` falls; the output bytes are 69,c4,…,5a in order; `err`=0.
- **Input gaps.** Toggle `in_valid` randomly at 50% while loading → same 128-bit values are assembled; no byte is dropped or duplicated.
- **Output backpressure.** `out_ready` low for 3 cycles at byte 5 → `out_data` stays constant across the stall; all 16 bytes are delivered in order.
- **Timeout.** TIMEOUT=20 and `core_done` never asserted → `err`=1 exactly 20 cycles after `core_rst` falls; `core_rst`=1; state LOAD_KEY; `out_valid` never asserted.
- **Coincident done and timeout.** `core_done` first asserted in the timeout cycle → ciphertext is unloaded and `err` stays 0.
- **Reset mid-operation.** `rst` pulsed at byte 20 of load and again at byte 7 of unload → every output returns to its reset value immediately; a fresh full frame then encrypts correctly.
